// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add multiplier that borrows the shared ALU adder,
// passing CPU ALU operands through while idle and stalling the CPU while running.
module alu_mul_seq #(
    parameter int         WORD_SIZE   = 18,
    parameter logic [3:0] ALU_OP_REG0 = 4'd0,
    parameter logic [3:0] ALU_OP_ADD  = 4'd2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] product,
    input  logic [WORD_SIZE-1:0] cpu_r0,
    input  logic [WORD_SIZE-1:0] cpu_r1,
    input  logic [3:0]           cpu_op,
    output logic                 cpu_stall,
    output logic [WORD_SIZE-1:0] alu_r0,
    output logic [WORD_SIZE-1:0] alu_r1,
    output logic [3:0]           alu_op,
    input  logic [WORD_SIZE-1:0] alu_res
);
    localparam int CW = $clog2(WORD_SIZE) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q;
    logic [WORD_SIZE-1:0] mcand_q, mplier_q, acc_q, product_q;
    logic [WORD_SIZE-1:0] acc_d;
    logic [CW-1:0]        cnt_q;
    logic                 done_q, idle, add, last;

    always_comb begin
        idle   = state_q == IDLE;
        add    = state_q == RUN && mplier_q[0];
        acc_d  = add ? alu_res : acc_q;
        // early exit once no multiplier bits remain, or after the last bit position
        last   = (mplier_q >> 1) == '0 || cnt_q == CW'(WORD_SIZE - 1);
        alu_r0 = idle ? cpu_r0 : acc_q;
        alu_r1 = idle ? cpu_r1 : mcand_q;
        alu_op = idle ? cpu_op : (add ? ALU_OP_ADD : ALU_OP_REG0);
    end

    assign busy      = !idle;
    assign cpu_stall = busy;
    assign done      = done_q;
    assign product   = product_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    mcand_q  <= a;
                    mplier_q <= b;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= RUN;
                end
                RUN: begin
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    acc_q    <= acc_d;
                    if (last) begin
                        product_q <= acc_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
